// File: rtl/rf_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rf_wb_arbiter_pkg
// Purpose : Shared constants for the register-file writeback arbiter slice.
//           Holds default widths and the one-bit grant encoding used to
//           remember which requester won the most recent transfer.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package rf_wb_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  // Grant encoding: identifies the requester that won the last transfer.
  typedef logic grant_t;
  localparam grant_t GNT_A = 1'b0;
  localparam grant_t GNT_B = 1'b1;

endpackage : rf_wb_arbiter_pkg
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : rf_scoreboard
// Purpose : Per-register busy scoreboard for RAW hazard detection.
//           A reservation sets a bit, a writeback commit clears it; when both
//           hit the same index in one cycle the reservation wins. Flags a
//           sticky error when a commit lands on a register that is not busy.
// Ports   : clk, reset            - clock, synchronous active-high reset
//           set_en / set_idx      - reserve register set_idx at the edge
//           clr_en / clr_idx      - commit (clear) register clr_idx at the edge
//           rd_idx1 / rd_idx2     - hazard lookup indices
//           busy1 / busy2         - combinational busy bits for the lookups
//           wb_err                - sticky commit-to-idle-register flag
// Revision: 1.0 - initial release
// ============================================================================
module rf_scoreboard
  import rf_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W_P = ADDR_W,
  parameter int NREGS_P  = NREGS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                set_en,
  input  logic [ADDR_W_P-1:0] set_idx,
  input  logic                clr_en,
  input  logic [ADDR_W_P-1:0] clr_idx,
  input  logic [ADDR_W_P-1:0] rd_idx1,
  input  logic [ADDR_W_P-1:0] rd_idx2,
  output logic                busy1,
  output logic                busy2,
  output logic                wb_err
);

  logic [NREGS_P-1:0] busy;
  logic [NREGS_P-1:0] busy_next;
  logic [NREGS_P-1:0] set_mask;
  logic [NREGS_P-1:0] clr_mask;
  logic               err_hit;

  // One-hot masks for the reservation and the commit.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_idx] = 1'b1;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
  end

  // Clear first, then OR in the set so a same-index reservation survives.
  assign busy_next = (busy & ~clr_mask) | set_mask;

  // Error judged on the pre-update bit: a commit must retire a reservation.
  assign err_hit = clr_en & ~busy[clr_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= '0;
      wb_err <= 1'b0;
    end else begin
      busy <= busy_next;
      if (err_hit) wb_err <= 1'b1;
    end
  end

  // No bypass of a same-cycle commit: lookups see the current vector only.
  assign busy1 = busy[rd_idx1];
  assign busy2 = busy[rd_idx2];

endmodule : rf_scoreboard
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rf_wb_arbiter
// Purpose : Shares the register file's single write port between requester A
//           (ALU) and requester B (load/memory). Round-robin grant, one-deep
//           registered output stage driving the RF write controls, plus a
//           busy scoreboard for issue-stage RAW hazard checks.
// Ports   : clk, reset                     - clock, sync active-high reset
//           a_valid/a_ready/a_dest/a_data  - requester A handshake + payload
//           b_valid/b_ready/b_dest/b_data  - requester B handshake + payload
//           iss_valid/iss_dest             - issue-stage register reservation
//           chk_scr1/chk_scr2, busy1/busy2 - hazard lookups
//           rf_read_l/rf_dest/rf_writeIn   - RF write strobe, index, data
//           wb_err                         - sticky bad-commit flag
// Revision: 1.0 - initial release
// ============================================================================
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int ADDR_W_P = ADDR_W,
  parameter int NREGS_P  = NREGS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [ADDR_W_P-1:0] a_dest,
  input  logic [DATA_W_P-1:0] a_data,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [ADDR_W_P-1:0] b_dest,
  input  logic [DATA_W_P-1:0] b_data,
  input  logic                iss_valid,
  input  logic [ADDR_W_P-1:0] iss_dest,
  input  logic [ADDR_W_P-1:0] chk_scr1,
  input  logic [ADDR_W_P-1:0] chk_scr2,
  output logic                busy1,
  output logic                busy2,
  output logic                rf_read_l,
  output logic [ADDR_W_P-1:0] rf_dest,
  output logic [DATA_W_P-1:0] rf_writeIn,
  output logic                wb_err
);

  grant_t last_grant;
  logic   a_xfer;
  logic   b_xfer;

  // ---------------------------------------------------------------------------
  // Grant: a lone requester always wins; under contention the requester that
  // did not win last time goes. Both readies are forced low during reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!reset) begin
      a_ready = a_valid & (~b_valid | (last_grant == GNT_B));
      b_ready = b_valid & (~a_valid | (last_grant == GNT_A));
    end
  end

  assign a_xfer = a_valid & a_ready;
  assign b_xfer = b_valid & b_ready;

  // ---------------------------------------------------------------------------
  // Output stage: the write strobe is high for exactly the cycle after a
  // transfer; index and data hold between transfers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_read_l  <= 1'b0;
      rf_dest    <= '0;
      rf_writeIn <= '0;
      last_grant <= GNT_B;
    end else if (a_xfer) begin
      rf_read_l  <= 1'b1;
      rf_dest    <= a_dest;
      rf_writeIn <= a_data;
      last_grant <= GNT_A;
    end else if (b_xfer) begin
      rf_read_l  <= 1'b1;
      rf_dest    <= b_dest;
      rf_writeIn <= b_data;
      last_grant <= GNT_B;
    end else begin
      rf_read_l  <= 1'b0;
    end
  end

  // The commit is the cycle the strobe is high; the bit clears at its end.
  rf_scoreboard #(
    .ADDR_W_P (ADDR_W_P),
    .NREGS_P  (NREGS_P)
  ) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_en  (iss_valid),
    .set_idx (iss_dest),
    .clr_en  (rf_read_l),
    .clr_idx (rf_dest),
    .rd_idx1 (chk_scr1),
    .rd_idx2 (chk_scr2),
    .busy1   (busy1),
    .busy2   (busy2),
    .wb_err  (wb_err)
  );

endmodule : rf_wb_arbiter
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_rf_wb_arbiter
// Purpose : Directed self-checking bench for rf_wb_arbiter. Inputs change
//           1 ns after the rising edge; outputs are compared 1 ns later.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [4:0]  a_dest, b_dest, iss_dest, chk_scr1, chk_scr2, rf_dest;
  logic [31:0] a_data, b_data, rf_writeIn;
  logic        iss_valid, busy1, busy2, rf_read_l, wb_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_dest     (a_dest),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_dest     (b_dest),
    .b_data     (b_data),
    .iss_valid  (iss_valid),
    .iss_dest   (iss_dest),
    .chk_scr1   (chk_scr1),
    .chk_scr2   (chk_scr2),
    .busy1      (busy1),
    .busy2      (busy2),
    .rf_read_l  (rf_read_l),
    .rf_dest    (rf_dest),
    .rf_writeIn (rf_writeIn),
    .wb_err     (wb_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then leave 1 ns for registered outputs to settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic reserve(input logic [4:0] r);
    iss_valid = 1'b1;
    iss_dest  = r;
    tick();
    iss_valid = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    a_valid = 0; b_valid = 0; a_dest = 0; b_dest = 0; a_data = 0; b_data = 0;
    iss_valid = 0; iss_dest = 0; chk_scr1 = 0; chk_scr2 = 0;

    // ---- reset --------------------------------------------------------------
    tick();
    tick();
    a_valid = 1'b1;
    settle();
    check_eq("a_ready_in_reset", a_ready, 0);
    a_valid = 1'b0;
    reset = 1'b0;
    settle();
    check_eq("rst_rf_read_l", rf_read_l, 0);
    check_eq("rst_rf_dest", rf_dest, 0);
    check_eq("rst_rf_writeIn", rf_writeIn, 0);
    check_eq("rst_busy1", busy1, 0);
    check_eq("rst_busy2", busy2, 0);
    check_eq("rst_wb_err", wb_err, 0);
    check_eq("idle_a_ready", a_ready, 0);
    check_eq("idle_b_ready", b_ready, 0);

    // ---- single A write to r4 ---------------------------------------------
    reserve(5'd4);
    chk_scr1 = 5'd4;
    settle();
    check_eq("r4_busy", busy1, 1);
    a_valid = 1'b1; a_dest = 5'd4; a_data = 32'hFFFF_FFFF;
    settle();
    check_eq("r4_a_ready", a_ready, 1);
    check_eq("r4_b_ready", b_ready, 0);
    tick();
    a_valid = 1'b0;
    settle();
    check_eq("r4_strobe", rf_read_l, 1);
    check_eq("r4_dest", rf_dest, 4);
    check_eq("r4_data", rf_writeIn, 32'hFFFF_FFFF);
    check_eq("r4_busy_no_bypass", busy1, 1);
    tick();
    check_eq("r4_strobe_off", rf_read_l, 0);
    check_eq("r4_busy_cleared", busy1, 0);
    check_eq("r4_dest_hold", rf_dest, 4);
    check_eq("r4_no_err", wb_err, 0);

    // ---- lone B write (r3) to leave last_grant=B, then A/B contention ------
    reserve(5'd3);
    reserve(5'd1);
    reserve(5'd2);
    b_valid = 1'b1; b_dest = 5'd3; b_data = 32'h33;
    settle();
    check_eq("r3_b_ready", b_ready, 1);
    tick();
    check_eq("r3_dest", rf_dest, 3);
    a_valid = 1'b1; a_dest = 5'd1; a_data = 32'h1;
    b_dest = 5'd2; b_data = 32'hDEAD_BEEF;
    settle();
    check_eq("cont_a_first", a_ready, 1);
    check_eq("cont_b_waits", b_ready, 0);
    tick();
    a_valid = 1'b0;
    settle();
    check_eq("cont_r1_strobe", rf_read_l, 1);
    check_eq("cont_r1_dest", rf_dest, 1);
    check_eq("cont_r1_data", rf_writeIn, 1);
    check_eq("cont_b_now", b_ready, 1);
    tick();
    b_valid = 1'b0;
    settle();
    check_eq("cont_r2_strobe", rf_read_l, 1);
    check_eq("cont_r2_dest", rf_dest, 2);
    check_eq("cont_r2_data", rf_writeIn, 32'hDEAD_BEEF);
    tick();
    chk_scr1 = 5'd1; chk_scr2 = 5'd2;
    settle();
    check_eq("cont_r1_free", busy1, 0);
    check_eq("cont_r2_free", busy2, 0);
    check_eq("cont_no_err", wb_err, 0);

    // ---- sustained contention: A,B,A,B,A,B into r5..r10 -------------------
    for (int r = 5; r <= 10; r++) reserve(5'(r));
    begin
      int ak = 0;
      int bk = 0;
      a_valid = 1'b1; b_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
        a_dest = 5'(5 + 2 * ak); a_data = 32'hA0 + 32'(ak);
        b_dest = 5'(6 + 2 * bk); b_data = 32'hB0 + 32'(bk);
        settle();
        check_eq($sformatf("alt%0d_a_ready", i), a_ready, (i % 2 == 0) ? 1 : 0);
        check_eq($sformatf("alt%0d_b_ready", i), b_ready, (i % 2 == 0) ? 0 : 1);
        tick();
        check_eq($sformatf("alt%0d_strobe", i), rf_read_l, 1);
        check_eq($sformatf("alt%0d_dest", i), rf_dest, 32'(5 + i));
        if (i % 2 == 0) begin
          check_eq($sformatf("alt%0d_data", i), rf_writeIn, 32'hA0 + 32'(ak));
          ak++;
        end else begin
          check_eq($sformatf("alt%0d_data", i), rf_writeIn, 32'hB0 + 32'(bk));
          bk++;
        end
      end
      a_valid = 1'b0; b_valid = 1'b0;
    end
    tick();
    check_eq("alt_strobe_off", rf_read_l, 0);
    check_eq("alt_no_err", wb_err, 0);

    // ---- r14: reserve during commit keeps busy; stray write raises wb_err ---
    reserve(5'd14);
    chk_scr1 = 5'd14;
    a_valid = 1'b1; a_dest = 5'd14; a_data = 32'h1414;
    tick();
    a_valid = 1'b0;
    iss_valid = 1'b1; iss_dest = 5'd14;
    settle();
    check_eq("r14_commit_strobe", rf_read_l, 1);
    tick();
    iss_valid = 1'b0;
    settle();
    check_eq("r14_set_wins", busy1, 1);
    check_eq("r14_no_err", wb_err, 0);
    a_valid = 1'b1; a_data = 32'h2828;
    tick();
    a_valid = 1'b0;
    tick();
    check_eq("r14_cleared", busy1, 0);
    check_eq("r14_still_no_err", wb_err, 0);
    a_valid = 1'b1; a_data = 32'h4242;
    tick();
    a_valid = 1'b0;
    settle();
    check_eq("r14_err_before_edge", wb_err, 0);
    tick();
    check_eq("r14_err_set", wb_err, 1);
    tick();
    tick();
    check_eq("r14_err_sticky", wb_err, 1);

    // ---- reset while a write is pending ------------------------------------
    reserve(5'd20);
    chk_scr1 = 5'd20;
    a_valid = 1'b1; a_dest = 5'd20; a_data = 32'h2020;
    tick();
    a_valid = 1'b0;
    check_eq("mid_pending_strobe", rf_read_l, 1);
    check_eq("mid_busy20", busy1, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check_eq("mid_strobe_dropped", rf_read_l, 0);
    check_eq("mid_busy_lost", busy1, 0);
    check_eq("mid_err_cleared", wb_err, 0);
    check_eq("mid_dest_zero", rf_dest, 0);
    check_eq("mid_data_zero", rf_writeIn, 0);
    a_valid = 1'b1; b_valid = 1'b1;
    settle();
    check_eq("mid_a_wins", a_ready, 1);
    check_eq("mid_b_loses", b_ready, 0);
    a_valid = 1'b0; b_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_rf_wb_arbiter
`default_nettype wire
